// File: rtl/alu16_pkg.sv
// alu16_pkg: shared constants for the alu16 execution-stage ALU.
//   ALU16_WIDTH : default datapath width (16 is the only verified value)
//   OP_ADD..OP_SAR : 3-bit opcode encodings for the eight operations
package alu16_pkg;

   localparam int unsigned ALU16_WIDTH = 16;

   localparam logic [2:0] OP_ADD = 3'b000;  // n + m + c
   localparam logic [2:0] OP_SUB = 3'b001;  // n - m - c (c is borrow)
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;  // ~n
   localparam logic [2:0] OP_SHL = 3'b110;  // shift left, c fills bit 0
   localparam logic [2:0] OP_SAR = 3'b111;  // arithmetic shift right

endpackage

// File: rtl/alu16_core.sv
// alu16_core: purely combinational next-result logic for alu16.
//   i_n, i_m : operands A and B (two's complement)
//   i_opc    : operation select (OP_* in alu16_pkg)
//   i_c      : carry/borrow-in, also the SHL fill bit
//   o_f      : next result, modulo 2^WIDTH
// Optional (macro ALU16_FLAGS_EXT_EN):
//   o_cout   : carry-out / no-borrow / shifted-out bit
//   o_ovf    : signed overflow for ADD/SUB, else 0
module alu16_core
   import alu16_pkg::*;
#(
   parameter int unsigned WIDTH = ALU16_WIDTH
)
(
   input  logic [WIDTH-1:0] i_n,
   input  logic [WIDTH-1:0] i_m,
   input  logic [2:0]       i_opc,
   input  logic             i_c,
   output logic [WIDTH-1:0] o_f
`ifdef ALU16_FLAGS_EXT_EN
   ,
   output logic             o_cout,
   output logic             o_ovf
`endif
);

   logic [WIDTH-1:0] w_cin;
   logic [WIDTH-1:0] w_add;
   logic [WIDTH-1:0] w_sub;

   assign w_cin = {{(WIDTH-1){1'b0}}, i_c};

`ifdef ALU16_FLAGS_EXT_EN
   logic w_add_c;
   logic w_sub_b;

   // One extra bit captures the carry-out of the add and the borrow-out of
   // the subtract; no borrow means n >= m + c when viewed as unsigned.
   assign {w_add_c, w_add} = {1'b0, i_n} + {1'b0, i_m} + {1'b0, w_cin};
   assign {w_sub_b, w_sub} = {1'b0, i_n} - {1'b0, i_m} - {1'b0, w_cin};
`else
   assign w_add = i_n + i_m + w_cin;
   assign w_sub = i_n - i_m - w_cin;
`endif

   always_comb begin
      o_f = '0;
      case (i_opc)
         OP_ADD:  o_f = w_add;
         OP_SUB:  o_f = w_sub;
         OP_AND:  o_f = i_n & i_m;
         OP_OR:   o_f = i_n | i_m;
         OP_XOR:  o_f = i_n ^ i_m;
         OP_NOT:  o_f = ~i_n;
         OP_SHL:  o_f = {i_n[WIDTH-2:0], i_c};
         OP_SAR:  o_f = {i_n[WIDTH-1], i_n[WIDTH-1:1]};
         default: o_f = '0;
      endcase
   end

`ifdef ALU16_FLAGS_EXT_EN
   always_comb begin
      o_cout = 1'b0;
      o_ovf  = 1'b0;
      case (i_opc)
         OP_ADD: begin
            o_cout = w_add_c;
            // Same-sign operands producing a differently signed result.
            o_ovf  = (i_n[WIDTH-1] == i_m[WIDTH-1]) &&
                     (w_add[WIDTH-1] != i_n[WIDTH-1]);
         end
         OP_SUB: begin
            o_cout = ~w_sub_b;
            // Opposite-sign operands where the result loses n's sign.
            o_ovf  = (i_n[WIDTH-1] != i_m[WIDTH-1]) &&
                     (w_sub[WIDTH-1] != i_n[WIDTH-1]);
         end
         OP_SHL:  o_cout = i_n[WIDTH-1];
         OP_SAR:  o_cout = i_n[0];
         default: begin
            o_cout = 1'b0;
            o_ovf  = 1'b0;
         end
      endcase
   end
`endif

endmodule

// File: rtl/alu16.sv
// alu16: registered two's-complement ALU, one operation per cycle, latency 1.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (f=0, zer=1, neg=0)
//   n, m : operands A and B
//   opc  : operation select (OP_* in alu16_pkg)
//   c    : carry/borrow-in, SHL fill bit
//   f    : registered result
//   zer  : registered, 1 when f == 0
//   neg  : registered, equals f[WIDTH-1]
// Optional (macro ALU16_FLAGS_EXT_EN): registered cout and ovf, reset to 0.
module alu16
   import alu16_pkg::*;
#(
   parameter int unsigned WIDTH = ALU16_WIDTH
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] n,
   input  logic [WIDTH-1:0] m,
   input  logic [2:0]       opc,
   input  logic             c,
   output logic [WIDTH-1:0] f,
   output logic             zer,
   output logic             neg
`ifdef ALU16_FLAGS_EXT_EN
   ,
   output logic             cout,
   output logic             ovf
`endif
);

   logic [WIDTH-1:0] w_f;
   logic [WIDTH-1:0] r_f;
   logic             r_zer;
   logic             r_neg;

`ifdef ALU16_FLAGS_EXT_EN
   logic w_cout;
   logic w_ovf;
   logic r_cout;
   logic r_ovf;
`endif

   alu16_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .i_n    (n),
      .i_m    (m),
      .i_opc  (opc),
      .i_c    (c),
      .o_f    (w_f)
`ifdef ALU16_FLAGS_EXT_EN
      ,
      .o_cout (w_cout),
      .o_ovf  (w_ovf)
`endif
   );

   // Flags come from the same next value that loads r_f, so they can never
   // lag the result by a cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_f   <= '0;
         r_zer <= 1'b1;
         r_neg <= 1'b0;
`ifdef ALU16_FLAGS_EXT_EN
         r_cout <= 1'b0;
         r_ovf  <= 1'b0;
`endif
      end else begin
         r_f   <= w_f;
         r_zer <= (w_f == '0);
         r_neg <= w_f[WIDTH-1];
`ifdef ALU16_FLAGS_EXT_EN
         r_cout <= w_cout;
         r_ovf  <= w_ovf;
`endif
      end
   end

   assign f   = r_f;
   assign zer = r_zer;
   assign neg = r_neg;
`ifdef ALU16_FLAGS_EXT_EN
   assign cout = r_cout;
   assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_alu16.sv
// tb_alu16: directed vectors with literal expectations plus a random stream
// checked every cycle against an integer-arithmetic reference model.
// Honours macro ALU16_FLAGS_EXT_EN (cout/ovf checks).
module tb_alu16;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] n;
   logic [15:0] m;
   logic [2:0]  opc;
   logic        c;
   logic [15:0] f;
   logic        zer;
   logic        neg;
`ifdef ALU16_FLAGS_EXT_EN
   logic        cout;
   logic        ovf;
`endif

   int checks = 0;
   int passes = 0;

   logic [15:0] exp_f;
   logic        exp_zer;
   logic        exp_neg;
   logic        exp_cout;
   logic        exp_ovf;
   logic        exp_valid = 1'b0;

   alu16 #(
      .WIDTH (16)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .n    (n),
      .m    (m),
      .opc  (opc),
      .c    (c),
      .f    (f),
      .zer  (zer),
      .neg  (neg)
`ifdef ALU16_FLAGS_EXT_EN
      ,
      .cout (cout),
      .ovf  (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
   endtask

   // Reference model on plain integers in 0..65535.
   function automatic int model_f(input int op, input int a, input int b, input int cin);
      case (op)
         0: return (a + b + cin) % 65536;
         1: return (a - b - cin + 131072) % 65536;
         2: return a & b;
         3: return a | b;
         4: return a ^ b;
         5: return 65535 - a;
         6: return (a * 2 + cin) % 65536;
         default: return a / 2 + ((a >= 32768) ? 32768 : 0);
      endcase
   endfunction

   function automatic int to_signed(input int a);
      return (a >= 32768) ? a - 65536 : a;
   endfunction

   function automatic bit model_cout(input int op, input int a, input int b, input int cin);
      case (op)
         0: return (a + b + cin) >= 65536;
         1: return a >= (b + cin);
         6: return a >= 32768;
         7: return (a % 2) == 1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit model_ovf(input int op, input int a, input int b, input int cin);
      int t;
      case (op)
         0: t = to_signed(a) + to_signed(b) + cin;
         1: t = to_signed(a) - to_signed(b) - cin;
         default: return 1'b0;
      endcase
      return (t > 32767) || (t < -32768);
   endfunction

   // Model: capture the inputs present at each rising edge.
   always @(posedge clk) begin
      int r;
      if (rst) begin
         exp_f = 16'h0000; exp_zer = 1'b1; exp_neg = 1'b0;
         exp_cout = 1'b0;  exp_ovf = 1'b0;
      end else begin
         r = model_f(int'(opc), int'(n), int'(m), int'(c));
         exp_f    = 16'(r);
         exp_zer  = (r == 0);
         exp_neg  = (r >= 32768);
         exp_cout = model_cout(int'(opc), int'(n), int'(m), int'(c));
         exp_ovf  = model_ovf(int'(opc), int'(n), int'(m), int'(c));
      end
      exp_valid = 1'b1;
   end

   // Compare process: outputs checked against the model every cycle.
   always @(negedge clk) begin
      if (exp_valid) begin
         chk("model_f",   32'(f),   32'(exp_f));
         chk("model_zer", 32'(zer), 32'(exp_zer));
         chk("model_neg", 32'(neg), 32'(exp_neg));
`ifdef ALU16_FLAGS_EXT_EN
         chk("model_cout", 32'(cout), 32'(exp_cout));
         chk("model_ovf",  32'(ovf),  32'(exp_ovf));
`endif
      end
   end

   // Drive one op, then look at the registered result just after the edge.
   task automatic op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                     input logic ci);
      opc = o; n = a; m = b; c = ci; rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   logic [15:0] sweep_f [8] = '{16'd11, 16'd5, 16'd0, 16'd11, 16'd11, 16'hFFF7, 16'd16, 16'd4};

   initial begin
      rst = 1'b1; n = 16'h1234; m = 16'hBEEF; opc = 3'd0; c = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_f",   32'(f),   32'h0);
      chk("reset_zer", 32'(zer), 32'h1);
      chk("reset_neg", 32'(neg), 32'h0);

      // Opcode sweep, first op issued immediately after reset release.
      for (int i = 0; i < 8; i++) begin
         op(3'(i), 16'd8, 16'd3, 1'b0);
         chk($sformatf("sweep_f_op%0d", i),   32'(f),   32'(sweep_f[i]));
         chk($sformatf("sweep_zer_op%0d", i), 32'(zer), 32'(i == 2));
         chk($sformatf("sweep_neg_op%0d", i), 32'(neg), 32'(i == 5));
      end

      op(3'd0, 16'd8, 16'd3, 1'b1); chk("cin_add", 32'(f), 32'd12);
      op(3'd1, 16'd8, 16'd3, 1'b1); chk("cin_sub", 32'(f), 32'd4);
      op(3'd6, 16'd8, 16'd3, 1'b1); chk("cin_shl", 32'(f), 32'd17);

      op(3'd1, 16'd3, 16'd3, 1'b0);
      chk("sub_zero_f", 32'(f), 32'h0);
      chk("sub_zero_zer", 32'(zer), 32'h1);
`ifdef ALU16_FLAGS_EXT_EN
      chk("sub_zero_cout", 32'(cout), 32'h1);
`endif

      op(3'd0, 16'h7FFF, 16'h0001, 1'b0);
      chk("wrap_f", 32'(f), 32'h8000);
      chk("wrap_neg", 32'(neg), 32'h1);
`ifdef ALU16_FLAGS_EXT_EN
      chk("wrap_ovf", 32'(ovf), 32'h1);
      chk("wrap_cout", 32'(cout), 32'h0);
`endif

      op(3'd7, 16'h8000, 16'h0000, 1'b1);
      chk("sar_f", 32'(f), 32'hC000);
      chk("sar_neg", 32'(neg), 32'h1);

      op(3'd5, 16'hFFFF, 16'h0000, 1'b0);
      chk("not_f", 32'(f), 32'h0);
      chk("not_zer", 32'(zer), 32'h1);

      // Random stream with a reset pulse in the middle.
      for (int i = 0; i < 1000; i++) begin
         n = 16'($urandom); m = 16'($urandom);
         opc = 3'($urandom); c = 1'($urandom);
         rst = (i == 500);
         @(posedge clk);
         #1;
         if (i == 500) begin
            chk("midrst_f",   32'(f),   32'h0);
            chk("midrst_zer", 32'(zer), 32'h1);
            chk("midrst_neg", 32'(neg), 32'h0);
         end
      end
      rst = 1'b0;
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
